// File: rtl/pu_pkg.sv
// Shared types and arithmetic helpers for the pu_pipe_n processing unit.
// PU_SATURATE_EN selects saturating adds in pu_add; otherwise adds wrap.
package pu_pkg;

    // Helpers work on a fixed 32-bit carrier; callers zero-extend XLEN-bit
    // operands and truncate the result, so XLEN must stay below PU_MAXW.
    localparam int PU_MAXW = 32;

    typedef enum logic {
        ACCUM   = 1'b0,
        PRESENT = 1'b1
    } pu_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // {3'b100, num[xlen-2:2]} built with shifts so any xlen >= 5 works.
    function automatic logic [PU_MAXW-1:0] pu_weight(input logic [PU_MAXW-1:0] num,
                                                     input int xlen);
        logic [PU_MAXW-1:0] low_mask;
        logic [PU_MAXW-1:0] high_bits;
        low_mask  = (PU_MAXW'(1) << (xlen - 3)) - PU_MAXW'(1);
        high_bits = PU_MAXW'(4) << (xlen - 3);
        return high_bits | ((num >> 2) & low_mask);
    endfunction

    function automatic logic [PU_MAXW-1:0] pu_add(input logic [PU_MAXW-1:0] a,
                                                  input logic [PU_MAXW-1:0] b,
                                                  input int xlen);
        logic [PU_MAXW-1:0] sum;
        logic [PU_MAXW-1:0] lim;
        sum = a + b;
        lim = (PU_MAXW'(1) << xlen) - PU_MAXW'(1);
`ifdef PU_SATURATE_EN
        if (sum > lim) begin
            sum = lim;
        end
`endif
        return sum & lim;
    endfunction

endpackage

// File: rtl/pu_tree_level.sv
// One registered adder-tree level: WIDTH_IN operands -> WIDTH_IN/2 pairwise sums.
// Latency 1 cycle; holds data and valid whenever i_en is low.
module pu_tree_level #(
    parameter int XLEN     = 5,
    parameter int WIDTH_IN = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_en,
    input  logic                             i_vld,
    input  logic [WIDTH_IN*XLEN-1:0]         i_dat,
    output logic                             o_vld,
    output logic [(WIDTH_IN/2)*XLEN-1:0]     o_dat
);
    import pu_pkg::*;

    localparam int WO = WIDTH_IN / 2;

    logic [WO*XLEN-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WO; i++) begin
            w_sum[i*XLEN +: XLEN] = XLEN'(pu_add(PU_MAXW'(i_dat[(2*i)*XLEN +: XLEN]),
                                                 PU_MAXW'(i_dat[(2*i+1)*XLEN +: XLEN]),
                                                 XLEN));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld <= 1'b0;
            o_dat <= '0;
        end else if (i_en) begin
            o_vld <= i_vld;
            if (i_vld) begin
                o_dat <= w_sum;
            end
        end
    end

endmodule

// File: rtl/pu_pipe_n.sv
// N-operand weight/sum/accumulate pipe; latency 2+log2(N) cycles per group, 1 beat/cycle.
// A held result (out_valid & ~out_ready) freezes every stage; PU_SATURATE_EN selects saturating adds.
module pu_pipe_n #(
    parameter int XLEN    = 5,
    parameter int N       = 4,
    parameter int ACC_LEN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*XLEN-1:0]   nums,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result
);
    import pu_pkg::*;

    localparam int LOG2N = clog2(N);
    localparam int CW    = (ACC_LEN > 1) ? clog2(ACC_LEN) : 1;
    // Every tree level lives in one flat bus: level l starts at XLEN*(2N - 2*(N>>l)).
    localparam int TW    = XLEN * (2*N - 1);

    logic                w_en;
    logic [N*XLEN-1:0]   w_wt;
    logic [TW-1:0]       w_tree;
    logic [LOG2N:0]      w_tvld;
    logic [XLEN-1:0]     w_sum;
    logic [XLEN-1:0]     w_acc_sum;
    logic [XLEN-1:0]     w_grp;
    logic                w_take;
    logic                w_last;

    logic                r_in_vld;
    logic [N*XLEN-1:0]   r_in_dat;
    pu_state_e           r_state;
    logic [XLEN-1:0]     r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_out_vld;
    logic [XLEN-1:0]     r_result;

    assign w_en      = ~(r_out_vld & ~out_ready);
    assign in_ready  = w_en;
    assign out_valid = r_out_vld;
    assign result    = r_result;

    always_comb begin
        w_wt = nums;
        for (int i = 0; i < N-1; i++) begin
            w_wt[i*XLEN +: XLEN] = XLEN'(pu_weight(PU_MAXW'(nums[i*XLEN +: XLEN]), XLEN));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_vld <= 1'b0;
            r_in_dat <= '0;
        end else if (w_en) begin
            r_in_vld <= in_valid;
            if (in_valid) begin
                r_in_dat <= w_wt;
            end
        end
    end

    assign w_tree[N*XLEN-1:0] = r_in_dat;
    assign w_tvld[0]          = r_in_vld;

    for (genvar l = 0; l < LOG2N; l++) begin : g_lvl
        localparam int WI = N >> l;
        localparam int OI = XLEN * (2*N - 2*WI);
        localparam int OO = XLEN * (2*N - WI);

        pu_tree_level #(
            .XLEN     (XLEN),
            .WIDTH_IN (WI)
        ) u_lvl (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_en),
            .i_vld (w_tvld[l]),
            .i_dat (w_tree[OI +: WI*XLEN]),
            .o_vld (w_tvld[l+1]),
            .o_dat (w_tree[OO +: (WI/2)*XLEN])
        );
    end

    assign w_sum     = w_tree[TW-1 -: XLEN];
    assign w_take    = w_tvld[LOG2N] & w_en;
    assign w_last    = (r_cnt == CW'(ACC_LEN - 1));
    assign w_acc_sum = XLEN'(pu_add(PU_MAXW'(r_acc), PU_MAXW'(w_sum), XLEN));
    assign w_grp     = (ACC_LEN == 1) ? w_sum : w_acc_sum;

    // In PRESENT the tree only advances when the consumer takes the result,
    // so a completing group can reload the output in that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
            r_result  <= '0;
        end else begin
            unique case (r_state)
                ACCUM: begin
                    if (w_take) begin
                        if (w_last) begin
                            r_result  <= w_grp;
                            r_cnt     <= '0;
                            r_out_vld <= 1'b1;
                            r_state   <= PRESENT;
                        end else begin
                            r_acc <= (r_cnt == '0) ? w_sum : w_acc_sum;
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (w_take && w_last) begin
                            r_result <= w_grp;
                            r_cnt    <= '0;
                        end else begin
                            r_out_vld <= 1'b0;
                            r_state   <= ACCUM;
                            if (w_take) begin
                                r_acc <= (r_cnt == '0) ? w_sum : w_acc_sum;
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_pu_pipe_n.sv
// Scoreboarded bench for pu_pipe_n: three configurations driven with directed beats.
// Build with PU_SATURATE_EN defined to check the saturating variant.
module tb_pu_pipe_n;

`ifdef PU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid0, in_valid1, in_valid2;
    logic        in_ready0, in_ready1, in_ready2;
    logic [19:0] nums0, nums1;
    logic [47:0] nums2;
    logic        out_valid0, out_valid1, out_valid2;
    logic        out_ready0, out_ready1, out_ready2;
    logic [4:0]  result0, result1;
    logic [5:0]  result2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int d;
        int val;
        int acc;
        bit lat;
    } exp_t;
    exp_t sb[$];

    bit stall_prev = 1'b0;
    int held       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pu_pipe_n #(.XLEN(5), .N(4), .ACC_LEN(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .nums(nums0),
        .out_valid(out_valid0), .out_ready(out_ready0), .result(result0));
    pu_pipe_n #(.XLEN(5), .N(4), .ACC_LEN(3)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .nums(nums1),
        .out_valid(out_valid1), .out_ready(out_ready1), .result(result1));
    pu_pipe_n #(.XLEN(6), .N(8), .ACC_LEN(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .nums(nums2),
        .out_valid(out_valid2), .out_ready(out_ready2), .result(result2));

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic mon(input int d, input int got);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out dut%0d: got result %0d, want no output", d, got);
        end else begin
            e = sb.pop_front();
            chk("out_dut", d, e.d);
            chk("out_result", got, e.val);
            if (e.lat) chk("out_latency", cyc - e.acc, (d == 2) ? 5 : 4);
        end
    endtask

    function automatic logic rdy(input int d);
        case (d)
            0:       return in_ready0;
            1:       return in_ready1;
            default: return in_ready2;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid0 && out_ready0) mon(0, int'(result0));
            if (out_valid1 && out_ready1) mon(1, int'(result1));
            if (out_valid2 && out_ready2) mon(2, int'(result2));
            if (out_valid0 && !out_ready0) begin
                chk("stall_in_ready", int'(in_ready0), 0);
                if (stall_prev) chk("stall_hold", int'(result0), held);
                stall_prev = 1'b1;
                held       = int'(result0);
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic beat(input int d, input logic [47:0] n, input bit push,
                        input int val, input bit lat);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        case (d)
            0:       begin in_valid0 = 1'b1; nums0 = n[19:0]; end
            1:       begin in_valid1 = 1'b1; nums1 = n[19:0]; end
            default: begin in_valid2 = 1'b1; nums2 = n;       end
        endcase
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rdy(d)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: in_ready 0, want 1", d);
        end else if (push) begin
            sb.push_back('{d, val, cyc, lat});
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
        repeat (8) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [47:0] n;
        rst = 1'b1;
        in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
        out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
        nums0 = '0; nums1 = '0; nums2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid0", int'(out_valid0), 0);
        chk("rst_out_valid1", int'(out_valid1), 0);
        chk("rst_out_valid2", int'(out_valid2), 0);
        chk("rst_in_ready0", int'(in_ready0), 1);
        chk("rst_in_ready1", int'(in_ready1), 1);
        chk("rst_in_ready2", int'(in_ready2), 1);
        chk("rst_result0", int'(result0), 0);
        chk("rst_result1", int'(result1), 0);
        chk("rst_result2", int'(result2), 0);

        // Single beat, weights 19,19,19 plus pass-through 3.
        beat(0, {28'd0, 5'd3, 5'd12, 5'd12, 5'd12}, 1'b1, SAT ? 31 : 28, 1'b1);
        idle();
        drain();

        // Three-beat accumulation, each tree sum 17.
        beat(1, {28'd0, 5'd1, 15'd0}, 1'b0, 0, 1'b0);
        beat(1, {28'd0, 5'd1, 15'd0}, 1'b0, 0, 1'b0);
        beat(1, {28'd0, 5'd1, 15'd0}, 1'b1, SAT ? 31 : 19, 1'b1);
        idle();
        drain();

        // Back-to-back stream with a 5-cycle consumer stall in the middle.
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    n = 48'(k) << 15;
                    beat(0, n, 1'b1, SAT ? 31 : 16 + k, 1'b0);
                end
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready0 = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready0 = 1'b1;
            end
        join
        drain();

        // Reset with a partial group in u1 and a beat in flight in u0.
        beat(1, {28'd0, 5'd1, 15'd0}, 1'b0, 0, 1'b0);
        idle();
        repeat (6) @(posedge clk);
        beat(0, {28'd0, 5'd3, 5'd12, 5'd12, 5'd12}, 1'b0, 0, 1'b0);
        idle();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid0", int'(out_valid0), 0);
        chk("post_rst_in_ready0", int'(in_ready0), 1);
        repeat (10) @(negedge clk);
        beat(0, 48'd12, 1'b1, SAT ? 31 : 19, 1'b1);
        idle();
        drain();
        beat(1, {28'd0, 5'd1, 15'd0}, 1'b0, 0, 1'b0);
        beat(1, {28'd0, 5'd1, 15'd0}, 1'b0, 0, 1'b0);
        beat(1, {28'd0, 5'd1, 15'd0}, 1'b1, SAT ? 31 : 19, 1'b1);
        idle();
        drain();

        // Eight-operand tree: seven weights of 32 plus 5.
        beat(2, 48'd5 << 42, 1'b1, SAT ? 63 : 37, 1'b1);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
